// File: rtl/sensor_adc_sequencer.sv
// Sensor ADC sequencer: walks the pending sensor requests lowest index first,
// settles the analog mux/bias, runs 2^AVG_LOG2 SAR conversions per sensor and
// emits one averaged byte per sensor with a single-cycle ready pulse.
module sensor_adc_sequencer #(
   parameter int unsigned AVG_LOG2    = 2,
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] senscode,
   input  logic       tx_enable,
   input  logic       adc_done,
   input  logic [7:0] adc_raw,
   output logic       adc_en,
   output logic [1:0] adc_sel,
   output logic       adc_start,
   output logic [7:0] ADC_data,
   output logic       ADC_data_ready,
   output logic [1:0] adc_sensor_id,
   output logic       adc_busy,
   output logic       adc_timeout_err
);

   localparam int unsigned ACC_W   = 8 + AVG_LOG2;
   localparam int unsigned NSAMP_W = AVG_LOG2 + 1;
   localparam int unsigned CNT_W   = $clog2(SETTLE_CYC + 1);
   localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYC + 1);

   localparam logic [NSAMP_W-1:0] NSAMP_LAST  = NSAMP_W'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_START,
      S_WAIT,
      S_OUTPUT,
      S_NEXT
   } state_t;

   state_t             state;
   logic [2:0]         pend;
   logic [1:0]         cur;
   logic [1:0]         low_idx;
   logic [2:0]         cur_mask;
   logic [CNT_W-1:0]   cnt;
   logic [TMO_W-1:0]   tmo;
   logic [NSAMP_W-1:0] nsamp;
   logic [ACC_W-1:0]   acc;
   logic               done_s1;
   logic               done_s2;
   logic               done_d;
   logic               done_evt;

   // adc_done is asynchronous: two-flop synchroniser followed by a rising-edge detector
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_s1 <= 1'b0;
         done_s2 <= 1'b0;
         done_d  <= 1'b0;
      end else begin
         done_s1 <= adc_done;
         done_s2 <= done_s1;
         done_d  <= done_s2;
      end
   end

   assign done_evt = done_s2 & ~done_d;
   assign cur_mask = 3'b001 << cur;

   // Lowest pending sensor index wins
   always_comb begin
      low_idx = 2'd0;
      if (pend[0])      low_idx = 2'd0;
      else if (pend[1]) low_idx = 2'd1;
      else if (pend[2]) low_idx = 2'd2;
   end

   // Sequencer FSM; cur is latched on entry to SETTLE so a late lower-index
   // request cannot switch the mux in the middle of a sensor's averaging run
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         pend            <= '0;
         cur             <= '0;
         cnt             <= '0;
         tmo             <= '0;
         nsamp           <= '0;
         acc             <= '0;
         adc_en          <= 1'b0;
         adc_sel         <= '0;
         adc_start       <= 1'b0;
         ADC_data        <= '0;
         ADC_data_ready  <= 1'b0;
         adc_sensor_id   <= '0;
         adc_busy        <= 1'b0;
         adc_timeout_err <= 1'b0;
      end else begin
         adc_start      <= 1'b0;
         ADC_data_ready <= 1'b0;
         pend           <= pend | senscode;

         case (state)
            S_IDLE: begin
               if (pend != '0 && !tx_enable) begin
                  state           <= S_SETTLE;
                  cur             <= low_idx;
                  adc_sel         <= low_idx;
                  adc_en          <= 1'b1;
                  adc_busy        <= 1'b1;
                  adc_timeout_err <= 1'b0;
                  cnt             <= '0;
                  acc             <= '0;
                  nsamp           <= '0;
               end
            end

            S_SETTLE: begin
               if (tx_enable) begin
                  state    <= S_IDLE;
                  adc_en   <= 1'b0;
                  adc_busy <= 1'b0;
                  acc      <= '0;
                  nsamp    <= '0;
               end else if (cnt == SETTLE_LAST) begin
                  state     <= S_START;
                  adc_start <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_START: begin
               if (tx_enable) begin
                  state    <= S_IDLE;
                  adc_en   <= 1'b0;
                  adc_busy <= 1'b0;
                  acc      <= '0;
                  nsamp    <= '0;
               end else begin
                  state <= S_WAIT;
                  tmo   <= '0;
               end
            end

            S_WAIT: begin
               if (tx_enable) begin
                  state    <= S_IDLE;
                  adc_en   <= 1'b0;
                  adc_busy <= 1'b0;
                  acc      <= '0;
                  nsamp    <= '0;
               end else if (done_evt) begin
                  acc   <= acc + ACC_W'(adc_raw);
                  nsamp <= nsamp + 1'b1;
                  if (nsamp == NSAMP_LAST) begin
                     state  <= S_OUTPUT;
                     adc_en <= 1'b0;
                  end else begin
                     state     <= S_START;
                     adc_start <= 1'b1;
                  end
               end else if (tmo == TMO_LAST) begin
                  state           <= S_NEXT;
                  adc_en          <= 1'b0;
                  adc_timeout_err <= 1'b1;
                  pend            <= (pend & ~cur_mask) | senscode;
                  acc             <= '0;
                  nsamp           <= '0;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end

            S_OUTPUT: begin
               state          <= S_NEXT;
               ADC_data       <= acc[AVG_LOG2 +: 8];
               adc_sensor_id  <= cur;
               ADC_data_ready <= 1'b1;
               pend           <= (pend & ~cur_mask) | senscode;
               acc            <= '0;
               nsamp          <= '0;
            end

            S_NEXT: begin
               if (pend != '0) begin
                  state   <= S_SETTLE;
                  cur     <= low_idx;
                  adc_sel <= low_idx;
                  adc_en  <= 1'b1;
                  cnt     <= '0;
                  acc     <= '0;
                  nsamp   <= '0;
               end else begin
                  state    <= S_IDLE;
                  adc_busy <= 1'b0;
               end
            end

            default: begin
               state    <= S_IDLE;
               adc_en   <= 1'b0;
               adc_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sensor_adc_sequencer.sv
// Self-checking bench for sensor_adc_sequencer: table of single-sensor
// averaging vectors plus directed multi-cycle sequences.
module tb_sensor_adc_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] senscode;
   logic       tx_enable;
   logic       adc_done;
   logic [7:0] adc_raw;
   logic       adc_en;
   logic [1:0] adc_sel;
   logic       adc_start;
   logic [7:0] ADC_data;
   logic       ADC_data_ready;
   logic [1:0] adc_sensor_id;
   logic       adc_busy;
   logic       adc_timeout_err;

   always #5 clk = ~clk;

   sensor_adc_sequencer #(
      .AVG_LOG2   (2),
      .SETTLE_CYC (16),
      .TIMEOUT_CYC(255)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .senscode       (senscode),
      .tx_enable      (tx_enable),
      .adc_done       (adc_done),
      .adc_raw        (adc_raw),
      .adc_en         (adc_en),
      .adc_sel        (adc_sel),
      .adc_start      (adc_start),
      .ADC_data       (ADC_data),
      .ADC_data_ready (ADC_data_ready),
      .adc_sensor_id  (adc_sensor_id),
      .adc_busy       (adc_busy),
      .adc_timeout_err(adc_timeout_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // monitor state
   int n_start = 0;
   int n_ready = 0;
   int sel_q[$];
   int settle_q[$];
   int data_q[$];
   int id_q[$];
   int settle_len = 0;
   bit in_settle = 1'b1;

   // ADC model state
   int raw_q[$];
   bit model_en = 1'b1;

   typedef struct packed {
      logic [2:0]  code;
      logic [31:0] raws;      // sample j in raws[8*j +: 8]
      logic [7:0]  exp_data;
      logic [1:0]  exp_id;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic clear_mon();
      n_start = 0;
      n_ready = 0;
      sel_q.delete();
      settle_q.delete();
      data_q.delete();
      id_q.delete();
   endtask

   task automatic pulse(input logic [2:0] code);
      @(negedge clk);
      senscode = code;
      @(negedge clk);
      senscode = 3'b000;
   endtask

   task automatic wait_ready(input int target, input int limit, input string name);
      int i = 0;
      while (n_ready < target && i < limit) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(n_ready >= target), 1);
   endtask

   task automatic wait_starts(input int target, input int limit, input string name);
      int i = 0;
      while (n_start < target && i < limit) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(n_start >= target), 1);
   endtask

   // Observe DUT outputs away from the active edge
   always @(negedge clk) begin
      if (!adc_en) begin
         settle_len = 0;
         in_settle  = 1'b1;
      end else if (adc_start) begin
         if (in_settle) settle_q.push_back(settle_len);
         in_settle = 1'b0;
      end else if (in_settle) begin
         settle_len++;
      end
      if (adc_start) begin
         n_start++;
         sel_q.push_back(int'(adc_sel));
      end
      if (ADC_data_ready) begin
         n_ready++;
         data_q.push_back(int'(ADC_data));
         id_q.push_back(int'(adc_sensor_id));
      end
   end

   // SAR ADC model: drop done on start, raise it with the next raw value 4 cycles later
   initial begin
      adc_done = 1'b0;
      adc_raw  = 8'd0;
      forever begin
         @(negedge clk);
         if (adc_start && model_en) begin
            adc_done = 1'b0;
            repeat (4) @(negedge clk);
            if (raw_q.size() > 0) adc_raw = 8'(raw_q.pop_front());
            else                  adc_raw = 8'd0;
            adc_done = 1'b1;
         end
      end
   end

   initial begin
      int bad;
      int s0;
      int r0;

      vecs[0] = '{code: 3'b001, raws: {8'd13,  8'd12,  8'd11,  8'd10},  exp_data: 8'd11,  exp_id: 2'd0};
      vecs[1] = '{code: 3'b100, raws: {8'd255, 8'd255, 8'd255, 8'd255}, exp_data: 8'd255, exp_id: 2'd2};
      vecs[2] = '{code: 3'b010, raws: {8'd3,   8'd0,   8'd0,   8'd0},   exp_data: 8'd0,   exp_id: 2'd1};
      vecs[3] = '{code: 3'b001, raws: {8'd5,   8'd3,   8'd2,   8'd1},   exp_data: 8'd2,   exp_id: 2'd0};
      vecs[4] = '{code: 3'b010, raws: {8'd104, 8'd102, 8'd101, 8'd100}, exp_data: 8'd101, exp_id: 2'd1};

      reset     = 1'b0;
      senscode  = 3'b000;
      tx_enable = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {24'd0, adc_en, adc_sel, adc_start, ADC_data_ready, adc_sensor_id, adc_busy, adc_timeout_err},
            0);
      check("reset_data", ADC_data, 0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_busy", adc_busy, 0);

      // table-driven single-sensor averaging
      for (int k = 0; k < 5; k++) begin
         clear_mon();
         raw_q.delete();
         for (int j = 0; j < 4; j++) raw_q.push_back(int'(vecs[k].raws[8*j +: 8]));
         pulse(vecs[k].code);
         wait_ready(1, 400, "vec_ready_seen");
         repeat (30) @(negedge clk);
         check("vec_data", data_q.size() > 0 ? data_q[0] : -1, vecs[k].exp_data);
         check("vec_id", id_q.size() > 0 ? id_q[0] : -1, vecs[k].exp_id);
         check("vec_starts", n_start, 4);
         check("vec_ready_count", n_ready, 1);
         check("vec_settle", settle_q.size() > 0 ? settle_q[0] : -1, 16);
         bad = 0;
         foreach (sel_q[i]) if (sel_q[i] != int'(vecs[k].exp_id)) bad++;
         check("vec_sel", bad, 0);
         check("vec_idle_busy", adc_busy, 0);
         check("vec_held_data", ADC_data, vecs[k].exp_data);
      end

      // two sensors requested together: sensor 0 then sensor 2
      clear_mon();
      raw_q.delete();
      foreach (vecs[0].raws[i]) begin end
      for (int j = 0; j < 4; j++) raw_q.push_back(4);
      for (int j = 0; j < 4; j++) raw_q.push_back(8 + j);
      pulse(3'b101);
      wait_ready(2, 600, "two_ready_seen");
      repeat (30) @(negedge clk);
      check("two_ready_count", n_ready, 2);
      check("two_data0", data_q.size() > 0 ? data_q[0] : -1, 4);
      check("two_id0", id_q.size() > 0 ? id_q[0] : -1, 0);
      check("two_data1", data_q.size() > 1 ? data_q[1] : -1, 9);
      check("two_id1", id_q.size() > 1 ? id_q[1] : -1, 2);
      check("two_starts", n_start, 8);
      check("two_settle_count", settle_q.size(), 2);
      check("two_settle0", settle_q.size() > 0 ? settle_q[0] : -1, 16);
      check("two_settle1", settle_q.size() > 1 ? settle_q[1] : -1, 16);
      bad = 0;
      foreach (sel_q[i]) if (sel_q[i] != (i < 4 ? 0 : 2)) bad++;
      check("two_sel_order", bad, 0);

      // conversion never completes: timeout path
      clear_mon();
      raw_q.delete();
      model_en = 1'b0;
      pulse(3'b010);
      wait_starts(1, 60, "tmo_start_seen");
      check("tmo_sel", sel_q.size() > 0 ? sel_q[0] : -1, 1);
      repeat (200) @(negedge clk);
      check("tmo_err_early", adc_timeout_err, 0);
      check("tmo_busy_waiting", adc_busy, 1);
      begin
         int i = 0;
         while (!adc_timeout_err && i < 100) begin
            @(negedge clk);
            i++;
         end
      end
      check("tmo_err_set", adc_timeout_err, 1);
      repeat (5) @(negedge clk);
      check("tmo_busy_after", adc_busy, 0);
      repeat (40) @(negedge clk);
      check("tmo_no_restart", n_start, 1);
      check("tmo_no_ready", n_ready, 0);
      check("tmo_err_sticky", adc_timeout_err, 1);
      model_en = 1'b1;

      // tx_enable aborts the third sample; full restart after it falls
      clear_mon();
      raw_q.delete();
      raw_q = '{30, 31, 99, 20, 21, 22, 23};
      pulse(3'b001);
      repeat (2) @(negedge clk);
      check("err_cleared_on_accept", adc_timeout_err, 0);
      wait_starts(3, 200, "abort_third_start");
      @(negedge clk);
      tx_enable = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_busy", adc_busy, 0);
      check("abort_en", adc_en, 0);
      repeat (10) @(negedge clk);
      check("abort_inhibit", adc_busy, 0);
      check("abort_no_ready", n_ready, 0);
      s0 = n_start;
      tx_enable = 1'b0;
      wait_ready(1, 400, "abort_restart_ready");
      repeat (30) @(negedge clk);
      check("abort_starts_total", n_start, s0 + 4);
      check("abort_ready_count", n_ready, 1);
      check("abort_data", data_q.size() > 0 ? data_q[0] : -1, 21);
      check("abort_id", id_q.size() > 0 ? id_q[0] : -1, 0);
      check("abort_err", adc_timeout_err, 0);

      // reset asserted mid-WAIT
      clear_mon();
      raw_q.delete();
      raw_q = '{40, 40, 40, 40};
      pulse(3'b001);
      wait_starts(2, 200, "rst_second_start");
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_async_outputs",
            {24'd0, adc_en, adc_sel, adc_start, ADC_data_ready, adc_sensor_id, adc_busy, adc_timeout_err},
            0);
      check("rst_async_data", ADC_data, 0);
      @(negedge clk);
      reset = 1'b1;
      s0 = n_start;
      r0 = n_ready;
      repeat (60) @(negedge clk);
      check("rst_no_restart", n_start, s0);
      check("rst_no_ready", n_ready, r0);
      check("rst_idle", adc_busy, 0);
      raw_q.delete();
      raw_q = '{50, 50, 50, 50};
      pulse(3'b100);
      wait_ready(r0 + 1, 400, "rst_recover_ready");
      repeat (5) @(negedge clk);
      check("rst_recover_data", ADC_data, 50);
      check("rst_recover_id", adc_sensor_id, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // absolute time guard
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
